spi_master_sched: RTL and testbench

//  Sequencer/arbiter that shares one master-mode spi_module and its clock_divider among NUM_REQ requesters.

---
 rtl/spi_sched_pkg.sv | 25 ++
 rtl/spi_master_sched_rr_arbiter.sv | 33 +++
 rtl/spi_master_sched.sv | 161 ++++++++++++++++
 tb/tb_spi_master_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared definitions for the SPI master scheduler.
//   - state encoding of the sequencer FSM
//   - default word width and watchdog counter width
package spi_sched_pkg;

  localparam int WORD_LEN_DEF = 8;
  localparam int TO_W         = 8;   // watchdog counter width

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_WAIT_DIV = 3'd1;
  localparam logic [2:0] S_WAIT_SPI = 3'd2;
  localparam logic [2:0] S_IDLE     = 3'd3;
  localparam logic [2:0] S_LAUNCH   = 3'd4;
  localparam logic [2:0] S_BUSY     = 3'd5;

  typedef enum logic [2:0] {
    ST_INIT     = S_INIT,
    ST_WAIT_DIV = S_WAIT_DIV,
    ST_WAIT_SPI = S_WAIT_SPI,
    ST_IDLE     = S_IDLE,
    ST_LAUNCH   = S_LAUNCH,
    ST_BUSY     = S_BUSY
  } state_t;

endpackage

// File: rtl/spi_master_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority index this round (must be < NUM_REQ)
//   gnt : one-hot grant of the first requester at or after ptr, wrapping; 0 if none
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  int             s;
  logic [PTR_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest hit wins last.
  always_comb begin
    gnt = '0;
    s   = 0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = PTR_W'(s);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_sched.sv
// spi_master_sched: shares one master spi_module + clock_divider among NUM_REQ
// requesters. Sequences both out of reset, grants round-robin with burst lock,
// drives the process_next_word / processing_word handshake and returns each
// received word to its owner. A watchdog aborts a stalled transfer.
// Ports:
//   WF_CLK, resetn (sync, active-low)
//   req/req_last/req_data   : per-requester word request, last flag, send word
//   grant/ack/rsp_data      : bus owner, word-done pulse, received word
//   err                     : 1-cycle watchdog abort pulse
//   busy                    : FSM not in IDLE
//   div_do_reset/div_is_ready, spi_do_reset/spi_is_ready : bring-up handshake
//   spi_next_word/spi_proc_word/spi_data_send/spi_data_recv : spi_module word port
module spi_master_sched
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WORD_LEN    = WORD_LEN_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                        WF_CLK,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*WORD_LEN-1:0] req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          ack,
  output logic [WORD_LEN-1:0]         rsp_data,
  output logic                        err,
  output logic                        busy,
  output logic                        div_do_reset,
  input  logic                        div_is_ready,
  output logic                        spi_do_reset,
  input  logic                        spi_is_ready,
  output logic                        spi_next_word,
  input  logic                        spi_proc_word,
  output logic [WORD_LEN-1:0]         spi_data_send,
  input  logic [WORD_LEN-1:0]         spi_data_recv
);

  localparam int              PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Abort once the FSM has spent TIMEOUT_CYC cycles in LAUNCH or BUSY.
  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYC - 1);

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic               last_q;
  logic [TO_W-1:0]    wd;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   nxt_ptr;
  logic               owner_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) owner = PTR_W'(i);
  end

  assign owner_req = |(req & grant);
  assign nxt_ptr   = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge WF_CLK) begin
    if (!resetn) begin
      state         <= ST_INIT;
      div_do_reset  <= 1'b1;
      spi_do_reset  <= 1'b1;
      grant         <= '0;
      ack           <= '0;
      err           <= 1'b0;
      spi_next_word <= 1'b0;
      spi_data_send <= '0;
      rsp_data      <= '0;
      rr_ptr        <= '0;
      last_q        <= 1'b0;
      wd            <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        ST_INIT: state <= ST_WAIT_DIV;

        // Release the reset first, move on the cycle after it is seen low.
        ST_WAIT_DIV: begin
          if (!div_do_reset)     state        <= ST_WAIT_SPI;
          else if (div_is_ready) div_do_reset <= 1'b0;
        end

        ST_WAIT_SPI: begin
          if (!spi_do_reset)                       state        <= ST_IDLE;
          else if (spi_is_ready && !spi_proc_word) spi_do_reset <= 1'b0;
        end

        ST_IDLE: begin
          wd <= '0;
          if (grant != '0) begin
            if (owner_req) begin
              state         <= ST_LAUNCH;
              spi_next_word <= 1'b1;
              spi_data_send <= req_data[owner*WORD_LEN +: WORD_LEN];
              last_q        <= req_last[owner];
            end else begin
              grant <= '0;            // owner dropped req between words
            end
          end else if (|req) begin
            grant <= arb_gnt;         // visible one cycle before launch
          end
        end

        ST_LAUNCH: begin
          if (spi_proc_word) begin
            spi_next_word <= 1'b0;
            state         <= ST_BUSY;
            wd            <= '0;
          end else if (wd == WD_LIMIT) begin
            err           <= 1'b1;
            grant         <= '0;
            spi_do_reset  <= 1'b1;
            spi_next_word <= 1'b0;
            state         <= ST_WAIT_SPI;
            wd            <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        ST_BUSY: begin
          if (!spi_proc_word) begin
            rsp_data <= spi_data_recv;
            ack      <= grant;
            state    <= ST_IDLE;
            wd       <= '0;
            if (last_q) begin
              grant  <= '0;
              rr_ptr <= nxt_ptr;
            end
          end else if (wd == WD_LIMIT) begin
            err           <= 1'b1;
            grant         <= '0;
            spi_do_reset  <= 1'b1;
            spi_next_word <= 1'b0;
            state         <= ST_WAIT_SPI;
            wd            <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
module tb_spi_master_sched;

  localparam int N  = 4;
  localparam int WL = 8;

  logic            WF_CLK = 1'b0;
  logic            resetn;
  logic [N-1:0]    req, req_last, grant, ack;
  logic [N*WL-1:0] req_data;
  logic [WL-1:0]   rsp_data, spi_data_send, spi_data_recv;
  logic            err, busy, div_do_reset, div_is_ready, spi_do_reset, spi_is_ready;
  logic            spi_next_word, spi_proc_word;

  spi_master_sched #(.NUM_REQ(N), .WORD_LEN(WL), .TIMEOUT_CYC(255)) dut (
    .WF_CLK        (WF_CLK),
    .resetn        (resetn),
    .req           (req),
    .req_last      (req_last),
    .req_data      (req_data),
    .grant         (grant),
    .ack           (ack),
    .rsp_data      (rsp_data),
    .err           (err),
    .busy          (busy),
    .div_do_reset  (div_do_reset),
    .div_is_ready  (div_is_ready),
    .spi_do_reset  (spi_do_reset),
    .spi_is_ready  (spi_is_ready),
    .spi_next_word (spi_next_word),
    .spi_proc_word (spi_proc_word),
    .spi_data_send (spi_data_send),
    .spi_data_recv (spi_data_recv)
  );

  always #5 WF_CLK = ~WF_CLK;

  typedef struct {
    int            idx;
    logic [WL-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  bit   stall  = 1'b0;
  int   mdl_cnt = 0;

  // spi_module model: proc_word rises 2 cycles after next_word, stays 16 cycles,
  // recv = ~send. Runs just after each rising edge.
  initial begin
    spi_proc_word = 1'b0;
    spi_data_recv = '0;
  end

  always @(posedge WF_CLK) begin
    #2;
    if (!resetn || spi_do_reset) begin
      mdl_cnt       = 0;
      spi_proc_word = 1'b0;
    end else if (!stall) begin
      if (mdl_cnt == 0) begin
        if (spi_next_word) mdl_cnt = 1;
      end else begin
        mdl_cnt++;
        if (mdl_cnt == 3) begin
          spi_proc_word = 1'b1;
          spi_data_recv = ~spi_data_send;
        end
        if (mdl_cnt == 19) begin
          spi_proc_word = 1'b0;
          mdl_cnt       = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One cycle; scoreboard pops and compares on every ack pulse.
  task automatic tick();
    exp_t e;
    @(negedge WF_CLK);
    cyc++;
    if (ack !== '0) begin
      if (exp_q.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("ack_owner", 32'(ack), 32'(1) << e.idx);
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  endtask

  task automatic wait_ack();
    int t = 0;
    do begin
      tick();
      t++;
    end while (ack == '0 && t < 200);
    if (ack == '0)
      chk("ack_timeout", 32'(ack), (exp_q.size() > 0) ? (32'(1) << exp_q[0].idx) : 32'd1);
  endtask

  task automatic set_word(input int i, input logic [WL-1:0] d, input logic last);
    req_data[i*WL +: WL] = d;
    req_last[i]          = last;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_div_rst"}, 32'(div_do_reset), 32'd1);
    chk({pfx, "_spi_rst"}, 32'(spi_do_reset), 32'd1);
    chk({pfx, "_grant"},   32'(grant), 32'd0);
    chk({pfx, "_ack"},     32'(ack), 32'd0);
    chk({pfx, "_err"},     32'(err), 32'd0);
    chk({pfx, "_busy"},    32'(busy), 32'd1);
    chk({pfx, "_next"},    32'(spi_next_word), 32'd0);
    chk({pfx, "_send"},    32'(spi_data_send), 32'd0);
    chk({pfx, "_rsp"},     32'(rsp_data), 32'd0);
  endtask

  initial begin
    int t;
    int l_cyc;
    resetn = 1'b0; req = '0; req_last = '0; req_data = '0;
    div_is_ready = 1'b0; spi_is_ready = 1'b0;

    // 1: reset values and bring-up ordering
    repeat (3) tick();
    chk_reset_outputs("rst");
    resetn = 1'b1;
    cyc = 0;
    while (cyc < 12) begin
      tick();
      case (cyc)
        5:  begin chk("t1_div_hi", 32'(div_do_reset), 32'd1); div_is_ready = 1'b1; end
        6:  chk("t1_div_lo", 32'(div_do_reset), 32'd0);
        9:  begin chk("t1_spi_hi", 32'(spi_do_reset), 32'd1); spi_is_ready = 1'b1; end
        10: begin chk("t1_spi_lo", 32'(spi_do_reset), 32'd0); chk("t1_busy10", 32'(busy), 32'd1); end
        11: chk("t1_busy11", 32'(busy), 32'd0);
        default: ;
      endcase
    end

    // 2: single word from requester 2
    set_word(2, 8'h9E, 1'b1); req[2] = 1'b1;
    exp_q.push_back('{idx: 2, data: 8'h61});
    t = 0; while (grant == '0 && t < 10) begin tick(); t++; end
    chk("t2_grant", 32'(grant), 32'b0100);
    t = 0; while (!spi_next_word && t < 10) begin tick(); t++; end
    chk("t2_send", 32'(spi_data_send), 32'h9E);
    wait_ack();
    chk("t2_grant_rel", 32'(grant), 32'd0);
    req[2] = 1'b0;
    tick();
    chk("t2_rsp_hold", 32'(rsp_data), 32'h61);

    // single word from 3 moves the rr pointer back to 0
    set_word(3, 8'h3C, 1'b1); req[3] = 1'b1;
    exp_q.push_back('{idx: 3, data: 8'hC3});
    wait_ack();
    req[3] = 1'b0;

    // 3: contention, req=1011 held, every word last
    set_word(0, 8'h20, 1'b1); set_word(1, 8'h21, 1'b1); set_word(3, 8'h23, 1'b1);
    exp_q.push_back('{idx: 0, data: 8'hDF});
    exp_q.push_back('{idx: 1, data: 8'hDE});
    exp_q.push_back('{idx: 3, data: 8'hDC});
    exp_q.push_back('{idx: 0, data: 8'hDF});
    exp_q.push_back('{idx: 1, data: 8'hDE});
    req = 4'b1011;
    for (int k = 0; k < 5; k++) wait_ack();
    req = '0;
    tick();
    chk("t3_idle_grant", 32'(grant), 32'd0);

    // 4: burst of three from requester 1 while requester 0 waits
    set_word(1, 8'hA1, 1'b0); req[1] = 1'b1;
    set_word(0, 8'hB0, 1'b1);
    exp_q.push_back('{idx: 1, data: 8'h5E});
    exp_q.push_back('{idx: 1, data: 8'h5D});
    exp_q.push_back('{idx: 1, data: 8'h5C});
    exp_q.push_back('{idx: 0, data: 8'h4F});
    t = 0; while (grant == '0 && t < 10) begin tick(); t++; end
    chk("t4_grant1", 32'(grant), 32'b0010);
    req[0] = 1'b1;
    wait_ack();
    chk("t4_lock1", 32'(grant), 32'b0010);
    set_word(1, 8'hA2, 1'b0);
    wait_ack();
    chk("t4_lock2", 32'(grant), 32'b0010);
    set_word(1, 8'hA3, 1'b1);
    wait_ack();
    chk("t4_release", 32'(grant), 32'd0);
    req[1] = 1'b0;
    t = 0; while (grant == '0 && t < 10) begin tick(); t++; end
    chk("t4_grant0", 32'(grant), 32'b0001);
    wait_ack();
    req[0] = 1'b0;

    // 5: stalled spi_module -> watchdog abort and recovery
    stall = 1'b1;
    set_word(3, 8'h55, 1'b1); req[3] = 1'b1;
    t = 0; while (!spi_next_word && t < 20) begin tick(); t++; end
    l_cyc = cyc;
    t = 0; while (!err && t < 300) begin tick(); t++; end
    chk("t5_err_time", 32'(cyc - l_cyc), 32'd255);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_spi_rst", 32'(spi_do_reset), 32'd1);
    chk("t5_div_rst", 32'(div_do_reset), 32'd0);
    req[3] = 1'b0;
    stall  = 1'b0;
    tick();
    chk("t5_err_pulse", 32'(err), 32'd0);
    chk("t5_spi_rst_rel", 32'(spi_do_reset), 32'd0);
    tick();
    chk("t5_idle", 32'(busy), 32'd0);
    set_word(2, 8'h5A, 1'b1); req[2] = 1'b1;
    exp_q.push_back('{idx: 2, data: 8'hA5});
    wait_ack();
    req[2] = 1'b0;

    // 6: reset while BUSY -> silent abort
    set_word(0, 8'h33, 1'b1); req[0] = 1'b1;
    t = 0; while (!spi_proc_word && t < 30) begin tick(); t++; end
    tick();
    chk("t6_in_busy", 32'(spi_next_word), 32'd0);
    resetn = 1'b0; req = '0;
    tick();
    chk_reset_outputs("t6");
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t6_quiet", 32'({ack, err}), 32'd0);
    end
    resetn = 1'b1;
    cyc = 0;
    t = 0; while (busy && t < 20) begin tick(); t++; end
    chk("t6_bringup", 32'(cyc), 32'd5);
    set_word(1, 8'hC3, 1'b1); req[1] = 1'b1;
    exp_q.push_back('{idx: 1, data: 8'h3C});
    wait_ack();
    req[1] = 1'b0;
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
